// File: rtl/oclib_reset_sequencer.sv
// Reset release sequencer: asserts all domain resets, holds them, then releases bit 0 first, one domain per stage.
// Optional OCLIB_RESET_SEQ_REVERSE_SHUTDOWN_EN: a soft request re-asserts domains top-down before replaying the release.
//
// state    | meaning
// HOLD     | all outputs asserted, counting AssertCycles
// RELEASE  | releasing outReset[idx] every StageCycles
// RUN      | all released, watching for a softReq rising edge
// SHUTDOWN | asserting outReset[idx] top-down every StageCycles (macro builds only)
module oclib_reset_sequencer #(
  parameter int Outputs      = 4,
  parameter int AssertCycles = 8,
  parameter int StageCycles  = 16
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               softReq,
  output logic               softAck,
  output logic [Outputs-1:0] outReset,
  output logic               allReleased,
  output logic               busy
);

  localparam int MaxCycles = (AssertCycles > StageCycles) ? AssertCycles : StageCycles;
  localparam int CW        = $clog2(MaxCycles + 1);
  localparam int IW        = (Outputs > 1) ? $clog2(Outputs) : 1;

  localparam logic [CW-1:0] AssertLast = CW'(AssertCycles - 1);
  localparam logic [CW-1:0] StageLast  = CW'(StageCycles - 1);
  localparam logic [IW-1:0] LastIdx    = IW'(Outputs - 1);

  localparam logic [1:0] HOLD     = 2'd0;
  localparam logic [1:0] RELEASE  = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;
`ifdef OCLIB_RESET_SEQ_REVERSE_SHUTDOWN_EN
  localparam logic [1:0] SHUTDOWN = 2'd3;
`endif

  if (Outputs < 1 || AssertCycles < 1 || StageCycles < 1) begin : g_param_check
    $error("oclib_reset_sequencer: Outputs, AssertCycles and StageCycles must all be >= 1");
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          softReqQ;
  logic          softActive;
  logic          softEdge;

  assign softEdge = softReq & ~softReqQ;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      softReqQ    <= 1'b0;
      softActive  <= 1'b0;
      outReset    <= '1;
      allReleased <= 1'b0;
      busy        <= 1'b1;
      softAck     <= 1'b0;
    end else begin
      // the delay register samples in every state, so a level held through a sequence is never an edge
      softReqQ <= softReq;
      softAck  <= 1'b0;
      case (state)
        HOLD: begin
          if (cnt == AssertLast) begin
            cnt         <= '0;
            outReset[0] <= 1'b0;
            if (Outputs == 1) begin
              state       <= RUN;
              allReleased <= 1'b1;
              busy        <= 1'b0;
              softAck     <= softActive;
              softActive  <= 1'b0;
            end else begin
              state <= RELEASE;
              idx   <= IW'(1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == StageLast) begin
            cnt           <= '0;
            outReset[idx] <= 1'b0;
            if (idx == LastIdx) begin
              state       <= RUN;
              allReleased <= 1'b1;
              busy        <= 1'b0;
              softAck     <= softActive;
              softActive  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (softEdge) begin
            softActive  <= 1'b1;
            allReleased <= 1'b0;
            busy        <= 1'b1;
            cnt         <= '0;
`ifdef OCLIB_RESET_SEQ_REVERSE_SHUTDOWN_EN
            outReset[Outputs-1] <= 1'b1;
            if (Outputs == 1) begin
              state <= HOLD;
            end else begin
              state <= SHUTDOWN;
              idx   <= IW'((Outputs > 1) ? Outputs - 2 : 0);
            end
`else
            outReset <= '1;
            state    <= HOLD;
`endif
          end
        end
`ifdef OCLIB_RESET_SEQ_REVERSE_SHUTDOWN_EN
        SHUTDOWN: begin
          if (cnt == StageLast) begin
            cnt           <= '0;
            outReset[idx] <= 1'b1;
            if (idx == '0) begin
              state <= HOLD;
            end else begin
              idx <= idx - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oclib_reset_sequencer.sv
// Bench for oclib_reset_sequencer: a 4/8/16 instance and a degenerate 1/1/1 instance against a timeline model.
module tb_oclib_reset_sequencer;

`ifdef OCLIB_RESET_SEQ_REVERSE_SHUTDOWN_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rb_a = 1'b0, req_a = 1'b0;
  logic       rb_b = 1'b0, req_b = 1'b0;
  logic       ack_a, all_a, busy_a;
  logic       ack_b, all_b, busy_b;
  logic [3:0] or_a;
  logic [0:0] or_b;

  oclib_reset_sequencer #(.Outputs(4), .AssertCycles(8), .StageCycles(16)) u_a (
    .clock(clk), .resetN(rb_a), .softReq(req_a), .softAck(ack_a),
    .outReset(or_a), .allReleased(all_a), .busy(busy_a)
  );

  oclib_reset_sequencer #(.Outputs(1), .AssertCycles(1), .StageCycles(1)) u_b (
    .clock(clk), .resetN(rb_b), .softReq(req_b), .softAck(ack_b),
    .outReset(or_b), .allReleased(all_b), .busy(busy_b)
  );

  int cmp_n = 0;
  int err_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is a timeline indexed by n = edges since its start edge.
  int P_O[2]  = '{4, 1};
  int P_AC[2] = '{8, 1};
  int P_SC[2] = '{16, 1};

  int m_kind[2];   // 0 hard, 1 soft forward, 2 soft reverse
  int m_n[2];
  bit m_run[2], m_prev[2], m_ack[2], s_rst[2], s_req[2];

  function automatic int tend(input int d, input int kind);
    int base = P_AC[d] + (P_O[d] - 1) * P_SC[d];
    return (kind == 2) ? base + (P_O[d] - 1) * P_SC[d] : base;
  endfunction

  function automatic logic [3:0] exp_bits(input int d, input int kind, input int n);
    logic [3:0] b = '0;
    int o = P_O[d], ac = P_AC[d], sc = P_SC[d];
    int n0 = (o - 1) * sc;
    for (int i = 0; i < o; i++) begin
      if (kind == 2) b[i] = (n >= (o - 1 - i) * sc) && !(n >= n0 + ac + i * sc);
      else           b[i] = !(n >= ac + i * sc);
    end
    return b;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_kind[d] = 0; m_n[d] = 0; m_run[d] = 0; m_prev[d] = 0;
      m_ack[d] = 0; s_rst[d] = 0; s_req[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bit rn, rq;
        logic [3:0] eb, ab;
        rn = (d == 0) ? rb_a : rb_b;
        rq = (d == 0) ? req_a : req_b;
        m_ack[d] = 1'b0;
        if (!rn) begin
          m_kind[d] = 0; m_n[d] = 0; m_run[d] = 0; m_prev[d] = 0;
        end else if (s_rst[d]) begin
          if (m_run[d]) begin
            if (s_req[d] && !m_prev[d]) begin
              m_kind[d] = REV ? 2 : 1;
              m_n[d]    = 0;
              m_run[d]  = 0;
            end
          end else begin
            m_n[d]++;
            if (m_n[d] == tend(d, m_kind[d])) begin
              m_run[d] = 1;
              m_ack[d] = (m_kind[d] != 0);
            end
          end
          m_prev[d] = s_req[d];
        end
        eb = m_run[d] ? 4'b0000 : exp_bits(d, m_kind[d], m_n[d]);
        if (d == 0) begin
          ab = or_a;
          chk("a_outReset", {28'd0, ab}, {28'd0, eb});
          chk("a_allReleased", {31'd0, all_a}, {31'd0, m_run[d]});
          chk("a_busy", {31'd0, busy_a}, {31'd0, ~m_run[d]});
          chk("a_softAck", {31'd0, ack_a}, {31'd0, m_ack[d]});
        end else begin
          ab = {3'b000, or_b};
          chk("b_outReset", {28'd0, ab}, {28'd0, eb});
          chk("b_allReleased", {31'd0, all_b}, {31'd0, m_run[d]});
          chk("b_busy", {31'd0, busy_b}, {31'd0, ~m_run[d]});
          chk("b_softAck", {31'd0, ack_b}, {31'd0, m_ack[d]});
        end
        s_rst[d] = rn;
        s_req[d] = rq;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    step(3);
    chk("lit_reset_or", {28'd0, or_a}, 32'hF);
    chk("lit_reset_busy", {31'd0, busy_a}, 32'd1);

    // degenerate instance
    rb_b = 1'b1;
    step(1);
    chk("lit_b_hard_or", {31'd0, or_b}, 32'd0);
    chk("lit_b_hard_all", {31'd0, all_b}, 32'd1);
    chk("lit_b_hard_ack", {31'd0, ack_b}, 32'd0);
    req_b = 1'b1;
    step(1);
    chk("lit_b_soft_or", {31'd0, or_b}, 32'd1);
    step(1);
    chk("lit_b_soft_rel", {31'd0, or_b}, 32'd0);
    chk("lit_b_soft_ack", {31'd0, ack_b}, 32'd1);
    step(1);
    chk("lit_b_ack_once", {31'd0, ack_b}, 32'd0);
    req_b = 1'b0;

    // hard release with ignored toggles while busy
    rb_a = 1'b1;
    step(7);
    chk("lit_e7", {28'd0, or_a}, 32'hF);
    step(1);
    chk("lit_e8", {28'd0, or_a}, 32'hE);
    req_a = 1'b1;
    step(16);
    chk("lit_e24", {28'd0, or_a}, 32'hC);
    req_a = 1'b0;
    step(16);
    chk("lit_e40", {28'd0, or_a}, 32'h8);
    req_a = 1'b1;
    step(15);
    chk("lit_e55", {28'd0, or_a}, 32'h8);
    chk("lit_e55_busy", {31'd0, busy_a}, 32'd1);
    step(1);
    chk("lit_e56", {28'd0, or_a}, 32'h0);
    chk("lit_e56_all", {31'd0, all_a}, 32'd1);
    chk("lit_e56_busy", {31'd0, busy_a}, 32'd0);
    chk("lit_e56_ack", {31'd0, ack_a}, 32'd0);
    step(5);
    chk("lit_held_no_soft", {28'd0, or_a}, 32'h0);
    req_a = 1'b0;

    // async reset mid-sequence
    rb_a = 1'b0;
    step(2);
    rb_a = 1'b1;
    step(30);
    chk("lit_e30", {28'd0, or_a}, 32'hC);
    rb_a = 1'b0;
    #1;
    chk("lit_async_or", {28'd0, or_a}, 32'hF);
    chk("lit_async_busy", {31'd0, busy_a}, 32'd1);
    step(2);
    rb_a = 1'b1;
    step(7);
    chk("lit_restart_e7", {28'd0, or_a}, 32'hF);
    step(1);
    chk("lit_restart_e8", {28'd0, or_a}, 32'hE);

    // softReq held high through reset into RUN
    req_a = 1'b1;
    rb_a = 1'b0;
    step(2);
    rb_a = 1'b1;
    step(60);
    chk("lit_held_reset_or", {28'd0, or_a}, 32'h0);
    chk("lit_held_reset_busy", {31'd0, busy_a}, 32'd0);
    req_a = 1'b0;
    step(2);

    // soft sequence
    req_a = 1'b1;
    step(1);
    chk("lit_soft_busy", {31'd0, busy_a}, 32'd1);
    chk("lit_soft_all", {31'd0, all_a}, 32'd0);
    if (REV) begin
      chk("lit_rev_p1", {28'd0, or_a}, 32'h8);
      step(16); chk("lit_rev_p17", {28'd0, or_a}, 32'hC);
      step(16); chk("lit_rev_p33", {28'd0, or_a}, 32'hE);
      step(16); chk("lit_rev_p49", {28'd0, or_a}, 32'hF);
      step(8);  chk("lit_rev_p57", {28'd0, or_a}, 32'hE);
      step(47); chk("lit_rev_p104", {28'd0, or_a}, 32'h8);
      chk("lit_rev_noack", {31'd0, ack_a}, 32'd0);
      step(1);  chk("lit_rev_p105", {28'd0, or_a}, 32'h0);
      chk("lit_rev_ack", {31'd0, ack_a}, 32'd1);
    end else begin
      chk("lit_fwd_p1", {28'd0, or_a}, 32'hF);
      step(8);  chk("lit_fwd_p9", {28'd0, or_a}, 32'hE);
      step(47); chk("lit_fwd_p56", {28'd0, or_a}, 32'h8);
      chk("lit_fwd_noack", {31'd0, ack_a}, 32'd0);
      step(1);  chk("lit_fwd_p57", {28'd0, or_a}, 32'h0);
      chk("lit_fwd_ack", {31'd0, ack_a}, 32'd1);
    end
    step(1);
    chk("lit_soft_ack_once", {31'd0, ack_a}, 32'd0);
    req_a = 1'b0;

    // randomized traffic on both instances, checked by the model
    for (int c = 0; c < 4000; c++) begin
      step(1);
      if ($urandom_range(0, 19) == 0) req_a = ~req_a;
      if ($urandom_range(0, 3) == 0)  req_b = ~req_b;
      if ($urandom_range(0, 999) == 0) begin
        rb_a = 1'b0;
        step($urandom_range(1, 3));
        rb_a = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        rb_b = 1'b0;
        step(1);
        rb_b = 1'b1;
      end
    end
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
